// File: rtl/dist_law_pkg.sv
// Shared types for the distributive-law engine: FSM states and output-width helper.
package dist_law_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMulS,
        StMulB,
        StMulC,
        StDone
    } state_e;

    localparam int unsigned ERR_CNT_W = 16;

    function automatic int unsigned out_width(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/booth_mul_seq.sv
// Radix-2 Booth sequential signed multiplier: N steps from start to a one-cycle done pulse.
// The first step is taken on the start edge, so done is high N-1 cycles after start.
module booth_mul_seq #(
    parameter int unsigned N = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int unsigned CW = $clog2(N + 1);

    logic signed [N:0] acc_q, m_q;
    logic [N-1:0]      q_q;
    logic              q1_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;

    logic signed [N:0] acc_cur, m_cur, acc_sum, acc_nxt;
    logic [N-1:0]      q_cur, q_nxt;
    logic              q1_cur, q1_nxt;

    // A start restarts from a clean accumulator, even while a previous product is on p.
    always_comb begin
        acc_cur = acc_q;
        m_cur   = m_q;
        q_cur   = q_q;
        q1_cur  = q1_q;
        if (start) begin
            acc_cur = '0;
            m_cur   = $signed({x[N-1], x});
            q_cur   = y;
            q1_cur  = 1'b0;
        end
        case ({q_cur[0], q1_cur})
            2'b01:   acc_sum = acc_cur + m_cur;
            2'b10:   acc_sum = acc_cur - m_cur;
            default: acc_sum = acc_cur;
        endcase
        acc_nxt = {acc_sum[N], acc_sum[N:1]};
        q_nxt   = {acc_sum[0], q_cur[N-1:1]};
        q1_nxt  = q_cur[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            m_q    <= '0;
            q_q    <= '0;
            q1_q   <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start || (busy_q && !done)) begin
            acc_q  <= acc_nxt;
            m_q    <= m_cur;
            q_q    <= q_nxt;
            q1_q   <= q1_nxt;
            cnt_q  <= start ? CW'(1) : cnt_q + CW'(1);
            busy_q <= 1'b1;
        end else if (done) begin
            busy_q <= 1'b0;
        end
    end

    assign done = busy_q && (cnt_q == CW'(N));
    assign busy = busy_q;
    assign p    = {acc_q[N-1:0], q_q};

endmodule

// File: rtl/dist_law_seq.sv
// Sequential engine computing a*(b+c) and a*b+a*c on one shared Booth multiplier.
// Optional mismatch counter on err_cnt is built only when DIST_LAW_ERRCNT_EN is defined.
module dist_law_seq
    import dist_law_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic [WIDTH-1:0]              c,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [out_width(WIDTH)-1:0]   out1,
    output logic [out_width(WIDTH)-1:0]   out2,
    output logic                          match,
    output logic [ERR_CNT_W-1:0]          err_cnt
);

    localparam int unsigned N  = WIDTH + 1;
    localparam int unsigned OW = out_width(WIDTH);

    state_e state_q, state_d;
    logic   live_q;

    logic signed [N-1:0]  a_q, b_q, c_q;
    logic signed [N-1:0]  a_ext, b_ext, c_ext, s_ext;
    logic signed [OW-1:0] p1_q, pb_q, out1_q, out2_q;
    logic signed [OW-1:0] prod, out2_d;
    logic                 match_q, match_d;

    logic                 accept, done_entry;
    logic                 mul_start, mul_busy, mul_done;
    logic [N-1:0]         mul_x, mul_y;
    logic [2*N-1:0]       mul_p;
    logic                 unused_mul;

    assign a_ext  = $signed({a[WIDTH-1], a});
    assign b_ext  = $signed({b[WIDTH-1], b});
    assign c_ext  = $signed({c[WIDTH-1], c});
    assign s_ext  = b_ext + c_ext;
    assign accept = in_valid && in_ready;

    // Product is exact in 2*WIDTH+1 bits; the top Booth bit is pure sign.
    assign prod       = $signed(mul_p[OW-1:0]);
    assign unused_mul = ^{mul_busy, mul_p[2*N-1]};
    assign out2_d     = pb_q + prod;
    assign match_d    = (p1_q == out2_d);

    // a*s is started straight from the inputs so each multiply state lasts N cycles.
    always_comb begin
        state_d    = state_q;
        mul_start  = 1'b0;
        mul_x      = a_q;
        mul_y      = b_q;
        done_entry = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mul_start = 1'b1;
                    mul_x     = a_ext;
                    mul_y     = s_ext;
                    state_d   = StMulS;
                end
            end
            StMulS: begin
                if (mul_done) begin
                    mul_start = 1'b1;
                    mul_y     = b_q;
                    state_d   = StMulB;
                end
            end
            StMulB: begin
                if (mul_done) begin
                    mul_start = 1'b1;
                    mul_y     = c_q;
                    state_d   = StMulC;
                end
            end
            StMulC: begin
                if (mul_done) begin
                    done_entry = 1'b1;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            live_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            p1_q    <= '0;
            pb_q    <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (accept) begin
                a_q <= a_ext;
                b_q <= b_ext;
                c_q <= c_ext;
            end
            if (state_q == StMulS && mul_done) begin
                p1_q <= prod;
            end
            if (state_q == StMulB && mul_done) begin
                pb_q <= prod;
            end
            // Visible results change only here, so they hold through backpressure and after.
            if (done_entry) begin
                out1_q  <= p1_q;
                out2_q  <= out2_d;
                match_q <= match_d;
            end
        end
    end

    booth_mul_seq #(
        .N(N)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .x     (mul_x),
        .y     (mul_y),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

`ifdef DIST_LAW_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (done_entry && !match_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign in_ready  = live_q && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out1      = out1_q;
    assign out2      = out2_q;
    assign match     = match_q;

endmodule

// File: tb/tb_dist_law_seq.sv
// Self-checking bench for dist_law_seq: cycle model of the handshake plus arithmetic reference.
module tb_dist_law_seq;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned OW       = 2 * WIDTH + 1;
    localparam int          DONE_EL  = 3 * (WIDTH + 1);
    localparam int          FAULT_PB = 100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready, match;
    logic [WIDTH-1:0] a, b, c;
    logic [OW-1:0]    out1, out2;
    logic [15:0]      err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dist_law_seq #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .out2      (out2),
        .match     (match),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input logic [WIDTH-1:0] v);
        return int'($signed(v));
    endfunction

    // Reference model: m_el counts edges since acceptance; results appear DONE_EL edges later.
    bit m_live = 0, m_busy = 0, m_match = 0, p_match = 0, fault_on = 0;
    int m_el = 0, m_o1 = 0, m_o2 = 0, m_err = 0, p_o1 = 0, p_o2 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live  <= 1'b0;
            m_busy  <= 1'b0;
            m_el    <= 0;
            m_o1    <= 0;
            m_o2    <= 0;
            m_match <= 1'b0;
            m_err   <= 0;
        end else begin
            m_live <= 1'b1;
            if (m_busy) begin
                if (m_el == DONE_EL) begin
                    if (out_ready) m_busy <= 1'b0;
                end else begin
                    m_el <= m_el + 1;
                    if (m_el + 1 == DONE_EL) begin
                        m_o1    <= p_o1;
                        m_o2    <= p_o2;
                        m_match <= p_match;
`ifdef DIST_LAW_ERRCNT_EN
                        if (!p_match && m_err < 65535) m_err <= m_err + 1;
`endif
                    end
                end
            end else if (m_live && in_valid) begin
                int av, bv, cv, pb;
                av = sx(a);
                bv = sx(b);
                cv = sx(c);
                pb = fault_on ? FAULT_PB : av * bv;
                p_o1    <= av * (bv + cv);
                p_o2    <= pb + av * cv;
                p_match <= (av * (bv + cv) == pb + av * cv);
                m_busy  <= 1'b1;
                m_el    <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_live && !m_busy);
        chk("out_valid", out_valid, m_busy && m_el == DONE_EL);
        chk("out1", $signed(out1), m_o1);
        chk("out2", $signed(out2), m_o2);
        chk("match", match, m_match);
        chk("err_cnt", err_cnt, m_err);
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int av, input int bv, input int cv, output time t_acc);
        bit ok = 1'b0;
        a = WIDTH'(av);
        b = WIDTH'(bv);
        c = WIDTH'(cv);
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept", ok, 1);
    endtask

    // lat = index of the first edge (accept edge = 0) that samples out_valid high.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int e = 1; e <= 100; e++) begin
            if (out_valid) begin
                lat = e;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int  lat;
        bit  hs;
        time ta, tb;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        c = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        // Directed triples with hand-computed results.
        send(-7, 2, -1, ta);
        wait_valid(lat);
        chk("t1_latency", lat, 16);
        chk("t1_out1", $signed(out1), -7);
        chk("t1_out2", $signed(out2), -7);
        chk("t1_match", match, 1);
        @(negedge clk);

        send(-5, 5, -8, ta);
        wait_valid(lat);
        chk("t2a_out1", $signed(out1), 15);
        chk("t2a_out2", $signed(out2), 15);
        @(negedge clk);
        send(-8, -6, 6, tb);
        chk("throughput", longint'((tb - ta) / 10), 17);
        wait_valid(lat);
        chk("t2b_out1", $signed(out1), 0);
        chk("t2b_match", match, 1);
        @(negedge clk);

        send(-8, -8, -8, ta);
        wait_valid(lat);
        chk("t3a_out1", $signed(out1), 128);
        chk("t3a_out2", $signed(out2), 128);
        @(negedge clk);
        send(-8, 7, 7, ta);
        wait_valid(lat);
        chk("t3b_out1", $signed(out1), -112);
        chk("t3b_out2", $signed(out2), -112);
        @(negedge clk);

        // Backpressure with stray in_valid pulses.
        out_ready = 1'b0;
        send(2, 3, -1, ta);
        wait_valid(lat);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = WIDTH'($urandom_range(0, 15));
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out1", $signed(out1), 4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_one_taken", out_valid, 0);
        chk("bp_held_out1", $signed(out1), 4);

        // Reset in the middle of a computation.
        send(5, -3, 6, ta);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out1", $signed(out1), 0);
        chk("abort_out2", $signed(out2), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(3, 1, 1, ta);
        wait_valid(lat);
        chk("t5_out1", $signed(out1), 6);
        chk("t5_out2", $signed(out2), 6);
        @(negedge clk);

        // Corrupted a*b product must surface as a mismatch.
        fault_on = 1'b1;
        force dut.pb_q = 9'sd100;
        send(3, 1, 1, ta);
        wait_valid(lat);
        chk("t6_out1", $signed(out1), 6);
        chk("t6_out2", $signed(out2), 103);
        chk("t6_match", match, 0);
`ifdef DIST_LAW_ERRCNT_EN
        chk("t6_err_cnt", err_cnt, 1);
`else
        chk("t6_err_cnt", err_cnt, 0);
`endif
        @(negedge clk);
        release dut.pb_q;
        fault_on = 1'b0;

        // Random triples, random backpressure and stray in_valid while busy.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), ta);
            hs = 1'b0;
            for (int i = 0; i < 200 && !hs; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                a = WIDTH'($urandom_range(0, 15));
                b = WIDTH'($urandom_range(0, 15));
                c = WIDTH'($urandom_range(0, 15));
                if (out_valid && out_ready) hs = 1'b1;
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("rand_handshake", hs, 1);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
